// File: rtl/config_bank_programmer_if.sv
// Stream and bitline/wordline bundle between the bitstream loader and the bank programmer.
// The master side feeds chunks and commands; the slave side drives the tile's bl/wl configuration ports.
interface config_bank_programmer_if #(
  parameter int NUM_BL  = 66,
  parameter int NUM_WL  = 66,
  parameter int CHUNK_W = 6
) ();

  logic               start;
  logic               abort;
  logic               in_valid;
  logic [CHUNK_W-1:0] in_data;
  logic               in_ready;
  logic [0:NUM_BL-1]  bl;
  logic [0:NUM_WL-1]  wl;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output abort,
    output in_valid,
    output in_data,
    input  in_ready,
    input  bl,
    input  wl,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  in_valid,
    input  in_data,
    output in_ready,
    output bl,
    output wl,
    output busy,
    output done
  );

endinterface

// File: rtl/config_bank_programmer.sv
// Memory-bank configuration writer: assembles one bitline word per row from a chunked stream,
// then frames a wordline pulse with setup/hold so wl is never high while bl moves.
module config_bank_programmer #(
  parameter int NUM_BL    = 66,
  parameter int NUM_WL    = 66,
  parameter int CHUNK_W   = 6,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input logic                    clk,
  input logic                    reset,
  config_bank_programmer_if.slave bus
);

  localparam int NUM_CHUNKS = NUM_BL / CHUNK_W;
  localparam int CHUNK_CW   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int ROW_W      = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int MAX_SP     = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC    = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int TIMER_W    = $clog2(MAX_CYC + 1);

  localparam logic [CHUNK_CW-1:0] LAST_CHUNK = CHUNK_CW'(NUM_CHUNKS - 1);
  localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(NUM_WL - 1);
  localparam logic [TIMER_W-1:0]  SETUP_LAST = TIMER_W'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0]  PULSE_LAST = TIMER_W'(PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0]  HOLD_LAST  = TIMER_W'(HOLD_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CHUNK_CW-1:0] chunk_q, chunk_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [0:NUM_BL-1]   shadow_q, shadow_d;
  logic [0:NUM_BL-1]   bl_q, bl_d;
  logic [0:NUM_WL-1]   wl_q, wl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    chunk_d  = chunk_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    bl_d     = bl_q;
    wl_d     = wl_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          row_d   = '0;
          chunk_d = '0;
          timer_d = '0;
        end
      end

      S_LOAD: begin
        if (bus.in_valid) begin
          for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (chunk_q == CHUNK_CW'(c)) begin
              for (int k = 0; k < CHUNK_W; k++) begin
                shadow_d[c*CHUNK_W + k] = bus.in_data[k];
              end
            end
          end
          // bl takes the completed word (including this last chunk) as SETUP begins
          if (chunk_q == LAST_CHUNK) begin
            chunk_d = '0;
            timer_d = '0;
            bl_d    = shadow_d;
            state_d = S_SETUP;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          timer_d = '0;
          state_d = S_PULSE;
          for (int r = 0; r < NUM_WL; r++) begin
            wl_d[r] = (row_q == ROW_W'(r));
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_PULSE: begin
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          wl_d    = '0;
          state_d = S_HOLD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          bl_d    = '0;
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        row_d   = '0;
        chunk_d = '0;
        timer_d = '0;
        bl_d    = '0;
        wl_d    = '0;
      end
    endcase

    // abort outranks start and any pending handshake, and drops the partial word
    if (bus.abort) begin
      state_d  = S_IDLE;
      row_d    = '0;
      chunk_d  = '0;
      timer_d  = '0;
      shadow_d = '0;
      bl_d     = '0;
      wl_d     = '0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      chunk_q  <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      chunk_q  <= chunk_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      bl_q     <= bl_d;
      wl_q     <= wl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready = (state_q == S_LOAD);
  assign bus.bl       = bl_q;
  assign bus.wl       = wl_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_config_bank_programmer.sv
// Directed bench for config_bank_programmer in a reduced 12x3 bank with 4-bit chunks.
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_config_bank_programmer;

  localparam int NUM_BL  = 12;
  localparam int NUM_WL  = 3;
  localparam int CHUNK_W = 4;

  // chunks 0xA,0x5,0xF land LSB-first into bl[0..3],bl[4..7],bl[8..11]
  localparam logic [0:NUM_BL-1] EXP_BL_STD = 12'b0101_1010_1111;
  // chunks 0x3,0xC,0x9
  localparam logic [0:NUM_BL-1] EXP_BL_BP  = 12'b1100_0011_1001;

  logic clk;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [CHUNK_W-1:0] row_chunks [3];
  int feed_idx;

  config_bank_programmer_if #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .CHUNK_W(CHUNK_W)) bus ();

  config_bank_programmer #(
    .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .CHUNK_W(CHUNK_W),
    .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // invariant monitor: records the first violation of each property
  logic [0:NUM_BL-1] bl_prev       = '0;
  logic              mon_onehot_bad = 1'b0;
  logic              mon_bl_bad     = 1'b0;
  logic              mon_ready_bad  = 1'b0;
  logic [0:NUM_WL-1] mon_bad_wl     = '0;

  always @(negedge clk) begin
    if (!$onehot0(bus.wl) && !mon_onehot_bad) begin
      mon_onehot_bad <= 1'b1;
      mon_bad_wl     <= bus.wl;
    end
    if ((|bus.wl) && (bus.bl !== bl_prev)) mon_bl_bad <= 1'b1;
    if (bus.in_ready && (!bus.busy || (|bus.wl) || bus.done || (bus.bl != '0)))
      mon_ready_bad <= 1'b1;
    bl_prev <= bus.bl;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_cycle();
    if (bus.in_ready) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_chunks[feed_idx];
      feed_idx     = (feed_idx + 1) % 3;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
    tick();
  endtask

  task automatic begin_pass(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
    row_chunks[0] = c0;
    row_chunks[1] = c1;
    row_chunks[2] = c2;
    feed_idx      = 0;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic abort_now();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b1;
    tick();
    bus.abort    = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    tests_run++;
    if ({bus.bl, bus.wl, bus.in_ready, bus.busy, bus.done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: bl=%b wl=%b in_ready=%b busy=%b done=%b, required all 0",
               bus.bl, bus.wl, bus.in_ready, bus.busy, bus.done);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({bus.in_ready, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: in_ready=%b busy=%b, required 0 0", bus.in_ready, bus.busy);
    end
    // start together with abort from IDLE must stay IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tests_run++;
    if ({bus.in_ready, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL abort_start_idle: in_ready=%b busy=%b, required 0 0", bus.in_ready, bus.busy);
    end
  endtask

  // Runs one pass for 30 sampled cycles; n=1 is the first in_ready cycle.
  // Expected: wl rows rise at n=5,12,19 for 2 cycles each; done at n=22 (3*7+1).
  task automatic run_pass_check(input string tag, input int start_at);
    int done_cnt = 0;
    int done_at  = 0;
    int high_cnt [3] = '{0, 0, 0};
    int first_hi [3] = '{0, 0, 0};
    int exp_first [3] = '{5, 12, 19};
    begin_pass(4'hA, 4'h5, 4'hF);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_load_entry: in_ready=%b busy=%b, required 1 1", tag, bus.in_ready, bus.busy);
    end
    for (int n = 1; n <= 30; n++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      for (int r = 0; r < NUM_WL; r++) begin
        if (bus.wl[r] === 1'b1) begin
          high_cnt[r]++;
          if (first_hi[r] == 0) first_hi[r] = n;
        end
      end
      if (|bus.wl) begin
        tests_run++;
        if (bus.bl !== EXP_BL_STD) begin
          tests_failed++;
          $display("[TB] FAIL %s_bl_word n=%0d: bl=%b, required %b", tag, n, bus.bl, EXP_BL_STD);
        end
      end
      if (n == start_at) begin
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s_start_in_load: in_ready=%b, required 1", tag, bus.in_ready);
        end
        bus.start = 1'b1;
      end
      feed_cycle();
      bus.start = 1'b0;
    end
    tests_run++;
    if (done_cnt != 1 || done_at != 22) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: pulses=%0d at n=%0d, required 1 at n=22", tag, done_cnt, done_at);
    end
    for (int r = 0; r < NUM_WL; r++) begin
      tests_run++;
      if (high_cnt[r] != 2 || first_hi[r] != exp_first[r]) begin
        tests_failed++;
        $display("[TB] FAIL %s_wl%0d: high %0d cycles from n=%0d, required 2 from n=%0d",
                 tag, r, high_cnt[r], first_hi[r], exp_first[r]);
      end
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle_after: busy=%b, required 0", tag, bus.busy);
    end
  endtask

  task automatic test_full_pass();
    run_pass_check("full_pass", 0);
  endtask

  task automatic test_backpressure();
    logic v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] d [6] = '{4'h3, 4'hF, 4'hF, 4'hC, 4'hF, 4'h9};
    begin_pass(4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL bp_ready_cycle%0d: in_ready=%b, required 1", i, bus.in_ready);
      end
      bus.in_valid = v[i];
      bus.in_data  = d[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.wl !== 3'b000 || bus.bl !== EXP_BL_BP) begin
      tests_failed++;
      $display("[TB] FAIL bp_setup: in_ready=%b wl=%b bl=%b, required 0 000 %b",
               bus.in_ready, bus.wl, bus.bl, EXP_BL_BP);
    end
    tick();
    tests_run++;
    if (bus.wl !== 3'b100 || bus.bl !== EXP_BL_BP) begin
      tests_failed++;
      $display("[TB] FAIL bp_pulse: wl=%b bl=%b, required 100 %b", bus.wl, bus.bl, EXP_BL_BP);
    end
    abort_now();
  endtask

  task automatic test_abort();
    int guard = 0;
    int done_cnt = 0;
    begin_pass(4'hA, 4'h5, 4'hF);
    while (bus.wl !== 3'b010 && guard < 40) begin
      feed_cycle();
      guard++;
    end
    tests_run++;
    if (bus.wl !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach_row1: wl=%b, required 010 within 40 cycles", bus.wl);
    end
    abort_now();
    tests_run++;
    if ({bus.wl, bus.bl, bus.busy, bus.done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: wl=%b bl=%b busy=%b done=%b, required all 0",
               bus.wl, bus.bl, bus.busy, bus.done);
    end
    for (int i = 0; i < 25; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
      tick();
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: %0d cycles with done/busy, required 0", done_cnt);
    end
    begin_pass(4'hA, 4'h5, 4'hF);
    guard = 0;
    while (bus.wl === 3'b000 && guard < 20) begin
      feed_cycle();
      guard++;
    end
    tests_run++;
    if (bus.wl !== 3'b100 || bus.bl !== EXP_BL_STD) begin
      tests_failed++;
      $display("[TB] FAIL abort_restart_row0: wl=%b bl=%b, required 100 %b", bus.wl, bus.bl, EXP_BL_STD);
    end
    abort_now();
  endtask

  task automatic test_async_reset();
    int guard = 0;
    begin_pass(4'hA, 4'h5, 4'hF);
    for (int i = 0; i < 3; i++) feed_cycle();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.bl !== EXP_BL_STD) begin
      tests_failed++;
      $display("[TB] FAIL areset_setup_reached: busy=%b in_ready=%b bl=%b, required 1 0 %b",
               bus.busy, bus.in_ready, bus.bl, EXP_BL_STD);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.wl, bus.bl, bus.busy} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL areset_mid_setup: wl=%b bl=%b busy=%b, required all 0", bus.wl, bus.bl, bus.busy);
    end
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.wl} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL areset_idle_after: in_ready=%b busy=%b wl=%b, required all 0",
               bus.in_ready, bus.busy, bus.wl);
    end
    begin_pass(4'hA, 4'h5, 4'hF);
    while (bus.wl === 3'b000 && guard < 20) begin
      feed_cycle();
      guard++;
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.wl !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL areset_mid_pulse: wl=%b, required 000", bus.wl);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    run_pass_check("start_busy", 16);
  endtask

  task automatic test_invariants();
    tests_run++;
    if (mon_onehot_bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wl_onehot0: saw wl=%b, required at most one bit set", mon_bad_wl);
    end
    tests_run++;
    if (mon_bl_bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bl_stable_under_wl: violation flag=%b, required 0", mon_bl_bad);
    end
    tests_run++;
    if (mon_ready_bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL in_ready_outside_load: violation flag=%b, required 0", mon_ready_bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
